fft_frame_uart: RTL and testbench
=================================

# fft_frame_uart

Frame-buffered FFT result streamer sitting between the FFT output stream and the UART link to the host MCU. It aligns on FFT frame boundaries, captures one full frame of bins (real part or magnitude estimate) into internal RAM, signals the MCU that a frame is ready, and serialises the frame over an 8N1 UART once the MCU grants. It generalises the single-width FIFO/UART path to parametrised data width, frame depth, baud divisor and output mode, and adds frame resync, host flow control and drop reporting.

## Interface
- DATA_W, 32, width of input re/im samples (signed) and of the stored word
- DEPTH, 1024, bins per frame; power of two, 8..4096
- CLK_DIV, 434, clock cycles per UART bit; at least 4
- MODE, 0, 0 = store re; 1 = store |re|+|im|, unsigned, saturated to DATA_W bits
- clk  in  1  system clock; every register runs on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- din_re  in  DATA_W  FFT real output, signed
- din_im  in  DATA_W  FFT imaginary output, signed; ignored when MODE=0
- din_valid  in  1  input sample valid
- din_last  in  1  qualifies the last bin of an FFT frame when din_valid=1
- rx_ready  in  1  MCU grant; high = MCU is receiving
- tx_ready  out  1  active-low frame-ready flag to MCU
- tx  out  1  UART serial output, idle high
- busy  out  1  high in WAIT_HOST and SEND
- frame_drop  out  1  one-cycle pulse when a frame is discarded
- frame_err  out  1  one-cycle pulse on a frame length mismatch

## Operation
- Bytes per word: BPW = ceil(DATA_W/8). Words are sent MSB byte first. Unused high bits of the top byte are zero-padded: sign-extended when MODE=0, zero when MODE=1.
- States are SYNC, FILL, WAIT_HOST and SEND.
- SYNC (entered after reset):
  - Discard samples until a beat with din_valid&din_last, then go to FILL.
  - The wr_ptr is 0 on entry to FILL.
- FILL:
  - Each din_valid beat writes the processed word to RAM[wr_ptr] and increments wr_ptr.
  - A beat with din_last at wr_ptr=DEPTH-1 completes the frame: go to WAIT_HOST and drive tx_ready low.
  - A beat with din_last at wr_ptr<DEPTH-1 is a short frame: pulse frame_err, reset wr_ptr to 0, stay in FILL. The next sample is bin 0.
  - A beat at wr_ptr=DEPTH-1 without din_last is a long frame: pulse frame_err and go to SYNC.
- WAIT_HOST:
  - Sampling rx_ready=1 enters SEND with rd_ptr=0 and byte index 0.
  - tx_ready stays low until the last stop bit of the frame has completed.
- SEND:
  - Byte sequence per word is BPW bytes, MSB byte first, then rd_ptr increments.
  - Each byte is 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1).
  - Bytes are sent back to back with no gap while rx_ready=1.
  - If rx_ready=0 is sampled at a byte boundary (end of a stop bit), hold tx=1 and pause. Resume with the next byte once rx_ready=1.
  - A byte already started always completes.
  - After the last stop bit of word DEPTH-1: tx_ready returns high and the block goes to SYNC.
- Any frame whose first beat arrives in WAIT_HOST or SEND is discarded. frame_drop pulses on that frame's din_last beat.
- MODE=1 arithmetic:
  - |x| of the most-negative value saturates to 2^(DATA_W-1).
  - The sum is computed in DATA_W+1 bits, then saturated to 2^DATA_W-1.

## Timing
- Reset values: tx=1, tx_ready=1, busy=0, frame_drop=0, frame_err=0, state SYNC, all pointers 0.
- Reset asserted mid-SEND forces tx=1 immediately, independent of clk. The partial frame is lost.
- The FILL write is registered: the processed word lands in RAM one cycle after the input beat.
- tx_ready falls on the cycle after the completing din_last beat. busy rises on the same cycle.
- The first start bit begins 2 cycles after rx_ready is first sampled high in WAIT_HOST (RAM read plus load).
- Bit period is exactly CLK_DIV cycles, so a byte takes 10*CLK_DIV cycles.
- Uninterrupted frame duration is DEPTH*BPW*10*CLK_DIV cycles.
- tx_ready rises, and busy falls, on the cycle after the final stop bit ends.
- frame_drop and frame_err are registered and appear on the cycle after the causing beat.
- din_last on the same beat that completes a frame is consumed by that frame. It does not cause a drop or an error.

## Test plan
Bench parameters for all scenarios: DATA_W=16, DEPTH=8, CLK_DIV=4 unless noted.
- Basic frame, MODE=0:
  - Stimulus: one junk frame ending in din_last, then bins re=0x0100..0x0107, last on bin 7, rx_ready held 1.
  - Required: tx_ready low 1 cycle after bin 7; first start bit 2 cycles after that.
  - Required: byte stream 01 00 01 01 … 01 07, 16 bytes in 640 cycles, then tx_ready=1.
- Magnitude, MODE=1:
  - Stimulus: re=-3, im=4 on bin 0; re=0x8000, im=0x8000 on bin 1.
  - Required: bin 0 word 0x0007; bin 1 word 0xFFFF (saturated).
- Host pause:
  - Stimulus: drop rx_ready mid-byte 3.
  - Required: byte 3 completes; tx holds 1 while rx_ready=0; byte 4 starts 1–2 cycles after rx_ready returns.
  - Required: decoded frame identical to the unpaused frame.
- Drop during send:
  - Stimulus: a second full frame arrives while in SEND.
  - Required: frame_drop pulses once, on the cycle after that frame's din_last; the transmitted data is unaffected.
- Length errors:
  - Stimulus: din_last on bin 5.
  - Required: frame_err pulse, then the following 8-bin frame is captured correctly.
  - Stimulus: a 9-bin frame.
  - Required: frame_err pulse, then resync, and the next frame is captured.
- Reset mid-SEND:
  - Stimulus: assert rst_n=0 during a data bit.
  - Required: tx=1, tx_ready=1, busy=0 asynchronously; after release, the block waits for din_last before capturing again.

Source files
------------

// File: rtl/fft_frame_uart.sv
// fft_frame_uart: captures one aligned FFT frame into RAM and streams it to
// the host MCU over an 8N1 UART once the host grants.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   din_re, din_im        FFT output sample (signed); din_im used only when MODE=1
//   din_valid, din_last   sample qualifier and end-of-frame marker
//   rx_ready              host grant, high while the MCU is receiving
//   tx_ready              active-low "frame ready" flag to the MCU
//   tx                    UART serial line, idle high
//   busy                  high while a captured frame waits for or is in transmission
//   frame_drop            one-cycle pulse on the last beat of a discarded frame
//   frame_err             one-cycle pulse on a short or long frame
module fft_frame_uart #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int CLK_DIV = 434,
   parameter int MODE    = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din_re,
   input  logic [DATA_W-1:0] din_im,
   input  logic              din_valid,
   input  logic              din_last,
   input  logic              rx_ready,
   output logic              tx_ready,
   output logic              tx,
   output logic              busy,
   output logic              frame_drop,
   output logic              frame_err
);

   localparam int BPW = (DATA_W + 7) / 8;
   localparam int PW  = BPW * 8;
   localparam int AW  = $clog2(DEPTH);
   localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int CW  = $clog2(CLK_DIV);

   typedef enum logic [1:0] {S_SYNC, S_FILL, S_WAIT, S_SEND} state_t;

   // |x| as an unsigned DATA_W value; the most-negative input maps to 2^(DATA_W-1)
   function automatic logic [DATA_W-1:0] abs_u(input logic signed [DATA_W-1:0] x);
      return x[DATA_W-1] ? ((~x) + DATA_W'(1)) : x;
   endfunction

   function automatic logic [DATA_W-1:0] sat_sum(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic [DATA_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[DATA_W] ? '1 : s[DATA_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] proc_word(input logic signed [DATA_W-1:0] re,
                                                   input logic signed [DATA_W-1:0] im);
      if (MODE == 0) return re;
      return sat_sum(abs_u(re), abs_u(im));
   endfunction

   // Widen a stored word to whole bytes: sign-extend real parts, zero-extend magnitudes
   function automatic logic [PW-1:0] pad_word(input logic [DATA_W-1:0] w);
      if (MODE == 0) return PW'($signed(w));
      return PW'(w);
   endfunction

   state_t            state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic              wr_en_q, wr_en_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] rd_data_q;
   logic [BW-1:0]     byte_idx_q, byte_idx_d;
   logic              byte_act_q, byte_act_d;
   logic              last_q, last_d;
   logic [8:0]        sh_q, sh_d;
   logic [3:0]        bit_idx_q, bit_idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              tx_q, tx_d;
   logic              tx_ready_q, tx_ready_d;
   logic              busy_q, busy_d;
   logic              frame_drop_q, frame_drop_d;
   logic              frame_err_q, frame_err_d;
   logic              mid_frame_q, mid_frame_d;
   logic              dropping_q, dropping_d;
   logic [PW-1:0]     cur_word;
   logic [7:0]        cur_byte;
   logic              load;
   logic              drop_now;

   logic [DATA_W-1:0] ram [DEPTH];

   assign cur_word = pad_word(rd_data_q);
   assign cur_byte = 8'(cur_word >> (8 * (BPW - 1 - int'(byte_idx_q))));

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_ptr_q;
      wr_data_d    = proc_word(din_re, din_im);
      rd_ptr_d     = rd_ptr_q;
      byte_idx_d   = byte_idx_q;
      byte_act_d   = byte_act_q;
      last_d       = last_q;
      sh_d         = sh_q;
      bit_idx_d    = bit_idx_q;
      cnt_d        = cnt_q;
      tx_d         = tx_q;
      tx_ready_d   = tx_ready_q;
      busy_d       = busy_q;
      frame_drop_d = 1'b0;
      frame_err_d  = 1'b0;
      mid_frame_d  = mid_frame_q;
      dropping_d   = dropping_q;
      load         = 1'b0;
      drop_now     = 1'b0;

      // A frame is dropped when its first beat lands while a captured frame is pending
      if (din_valid) begin
         mid_frame_d = !din_last;
         drop_now    = dropping_q ||
                       (!mid_frame_q && (state_q == S_WAIT || state_q == S_SEND));
         if (din_last) begin
            frame_drop_d = drop_now;
            dropping_d   = 1'b0;
         end else begin
            dropping_d   = drop_now;
         end
      end

      case (state_q)
         S_SYNC: begin
            wr_ptr_d = '0;
            if (din_valid && din_last) state_d = S_FILL;
         end
         S_FILL: begin
            if (din_valid) begin
               wr_en_d = 1'b1;
               if (din_last) begin
                  wr_ptr_d = '0;
                  if (wr_ptr_q == AW'(DEPTH - 1)) begin
                     state_d    = S_WAIT;
                     tx_ready_d = 1'b0;
                     busy_d     = 1'b1;
                  end else begin
                     frame_err_d = 1'b1;
                  end
               end else if (wr_ptr_q == AW'(DEPTH - 1)) begin
                  frame_err_d = 1'b1;
                  wr_ptr_d    = '0;
                  state_d     = S_SYNC;
               end else begin
                  wr_ptr_d = wr_ptr_q + AW'(1);
               end
            end
         end
         S_WAIT: begin
            rd_ptr_d   = '0;
            byte_idx_d = '0;
            byte_act_d = 1'b0;
            last_d     = 1'b0;
            if (rx_ready) state_d = S_SEND;
         end
         default: begin
            if (!byte_act_q) begin
               load = rx_ready;
            end else if (cnt_q == CW'(CLK_DIV - 1)) begin
               cnt_d = '0;
               if (bit_idx_q != 4'd9) begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  tx_d      = sh_q[0];
                  sh_d      = sh_q >> 1;
               end else if (last_q) begin
                  state_d    = S_SYNC;
                  tx_ready_d = 1'b1;
                  busy_d     = 1'b0;
                  byte_act_d = 1'b0;
                  rd_ptr_d   = '0;
               end else if (rx_ready) begin
                  load = 1'b1;
               end else begin
                  byte_act_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
            // Start bit goes out immediately; stop bit rides in sh_q[8]
            if (load) begin
               sh_d       = {1'b1, cur_byte};
               tx_d       = 1'b0;
               bit_idx_d  = '0;
               cnt_d      = '0;
               byte_act_d = 1'b1;
               last_d     = (byte_idx_q == BW'(BPW - 1)) && (rd_ptr_q == AW'(DEPTH - 1));
               if (byte_idx_q == BW'(BPW - 1)) begin
                  byte_idx_d = '0;
                  rd_ptr_d   = rd_ptr_q + AW'(1);
               end else begin
                  byte_idx_d = byte_idx_q + BW'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_SYNC;
         wr_ptr_q     <= '0;
         wr_en_q      <= 1'b0;
         rd_ptr_q     <= '0;
         byte_idx_q   <= '0;
         byte_act_q   <= 1'b0;
         last_q       <= 1'b0;
         bit_idx_q    <= '0;
         cnt_q        <= '0;
         tx_q         <= 1'b1;
         tx_ready_q   <= 1'b1;
         busy_q       <= 1'b0;
         frame_drop_q <= 1'b0;
         frame_err_q  <= 1'b0;
         mid_frame_q  <= 1'b0;
         dropping_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         wr_en_q      <= wr_en_d;
         rd_ptr_q     <= rd_ptr_d;
         byte_idx_q   <= byte_idx_d;
         byte_act_q   <= byte_act_d;
         last_q       <= last_d;
         bit_idx_q    <= bit_idx_d;
         cnt_q        <= cnt_d;
         tx_q         <= tx_d;
         tx_ready_q   <= tx_ready_d;
         busy_q       <= busy_d;
         frame_drop_q <= frame_drop_d;
         frame_err_q  <= frame_err_d;
         mid_frame_q  <= mid_frame_d;
         dropping_q   <= dropping_d;
      end
   end

   // Datapath: registered write port, registered read port, shifter
   always_ff @(posedge clk) begin
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sh_q      <= sh_d;
      rd_data_q <= ram[rd_ptr_q];
      if (wr_en_q) ram[wr_addr_q] <= wr_data_q;
   end

   assign tx         = tx_q;
   assign tx_ready   = tx_ready_q;
   assign busy       = busy_q;
   assign frame_drop = frame_drop_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_frame_uart.sv
// Bench for fft_frame_uart: one MODE=0 and one MODE=1 instance share stimulus;
// each serial line is decoded back into bytes and compared with a model.
module tb_fft_frame_uart;

   localparam int DW  = 16;
   localparam int DEP = 8;
   localparam int CD  = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] din_re, din_im;
   logic          din_valid, din_last, rx_ready;
   logic          txr [2];
   logic          txs [2];
   logic          bsy [2];
   logic          fd [2];
   logic          fe [2];

   fft_frame_uart #(.DATA_W(DW), .DEPTH(DEP), .CLK_DIV(CD), .MODE(0)) u_re (
      .clk(clk), .rst_n(rst_n), .din_re(din_re), .din_im(din_im),
      .din_valid(din_valid), .din_last(din_last), .rx_ready(rx_ready),
      .tx_ready(txr[0]), .tx(txs[0]), .busy(bsy[0]),
      .frame_drop(fd[0]), .frame_err(fe[0]));

   fft_frame_uart #(.DATA_W(DW), .DEPTH(DEP), .CLK_DIV(CD), .MODE(1)) u_mag (
      .clk(clk), .rst_n(rst_n), .din_re(din_re), .din_im(din_im),
      .din_valid(din_valid), .din_last(din_last), .rx_ready(rx_ready),
      .tx_ready(txr[1]), .tx(txs[1]), .busy(bsy[1]),
      .frame_drop(fd[1]), .frame_err(fe[1]));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // UART receivers: sample each bit in its middle, record bytes and start cycles
   int         ph [2];
   bit         act [2];
   logic [7:0] dat [2];
   logic [7:0] rxb [2][512];
   int         stc [2][512];
   int         rxn [2];
   int         stopbad [2];
   int         fd_cnt [2];
   int         fe_cnt [2];

   initial begin
      for (int g = 0; g < 2; g++) begin
         rxn[g] = 0; stopbad[g] = 0; fd_cnt[g] = 0; fe_cnt[g] = 0;
         act[g] = 0; ph[g] = 0; dat[g] = 8'h00;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_dec
      always @(negedge clk) begin
         if (fd[g] === 1'b1) fd_cnt[g] <= fd_cnt[g] + 1;
         if (fe[g] === 1'b1) fe_cnt[g] <= fe_cnt[g] + 1;
         if (!rst_n) begin
            act[g] <= 1'b0;
            ph[g]  <= 0;
         end else if (!act[g]) begin
            if (txs[g] == 1'b0) begin
               act[g] <= 1'b1;
               ph[g]  <= 1;
               if (rxn[g] < 512) stc[g][rxn[g]] <= cyc;
            end
         end else begin
            ph[g] <= ph[g] + 1;
            if (ph[g] == CD * 10 - CD / 2) begin
               if (txs[g] !== 1'b1) stopbad[g] <= stopbad[g] + 1;
               if (rxn[g] < 512) rxb[g][rxn[g]] <= dat[g];
               rxn[g] <= rxn[g] + 1;
               act[g] <= 1'b0;
            end else if (ph[g] > CD && (ph[g] % CD) == CD / 2) begin
               dat[g] <= {txs[g], dat[g][7:1]};
            end
         end
      end
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string nm, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic check_rng(input string nm, input int got, input int lo, input int hi);
      n_checks++;
      if (got < lo || got > hi) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d..%0d", nm, got, lo, hi);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_until(input int target);
      while (cyc < target) tick();
   endtask

   // Reference: stored word per the output-mode rules, computed with plain integers
   function automatic int model_word(input int mode, input int re16, input int im16);
      int r, i, a, b, s;
      if (mode == 0) return re16;
      r = (re16 >= 32768) ? re16 - 65536 : re16;
      i = (im16 >= 32768) ? im16 - 65536 : im16;
      a = (r < 0) ? -r : r;
      b = (i < 0) ? -i : i;
      s = a + b;
      return (s > 65535) ? 65535 : s;
   endfunction

   function automatic int dec_word(input int g, input int base, input int w);
      return int'(rxb[g][base + 2*w]) * 256 + int'(rxb[g][base + 2*w + 1]);
   endfunction

   int fre [9];
   int fim [9];

   task automatic send_beat(input int re, input int im, input bit last, input bit gap);
      din_re    = 16'(re);
      din_im    = 16'(im);
      din_valid = 1'b1;
      din_last  = last;
      tick();
      din_valid = 1'b0;
      din_last  = 1'b0;
      if (gap) tick();
   endtask

   task automatic send_frame(input int n);
      for (int i = 0; i < n; i++)
         send_beat(fre[i], fim[i], i == n - 1, (i < n - 1) && ($urandom_range(0, 3) == 0));
   endtask

   task automatic rand_frame();
      for (int i = 0; i < 9; i++) begin
         fre[i] = int'($urandom_range(0, 65535));
         fim[i] = int'($urandom_range(0, 65535));
      end
   endtask

   task automatic junk_align();
      int n;
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++)
         send_beat(int'($urandom_range(0, 65535)), 0, i == n - 1, 1'b0);
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         if (txr[0] === 1'b1 && txr[1] === 1'b1) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) check({nm, "_timeout"}, 0, 1);
      tick();
   endtask

   task automatic check_frame(input string nm, input int b0, input int b1);
      int base;
      for (int g = 0; g < 2; g++) begin
         base = (g == 0) ? b0 : b1;
         check($sformatf("%s_m%0d_bytes", nm, g), rxn[g] - base, 2 * DEP);
         for (int w = 0; w < DEP; w++)
            check($sformatf("%s_m%0d_w%0d", nm, g, w), dec_word(g, base, w),
                  model_word(g, fre[w], fim[w]));
      end
   endtask

   typedef struct {
      logic [15:0] re;
      logic [15:0] im;
      logic [15:0] w0;
      logic [15:0] w1;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, b1, e, s0, bad, d, fdc, fec;

      tbl[0] = '{16'hFFFD, 16'h0004, 16'hFFFD, 16'h0007};
      tbl[1] = '{16'h8000, 16'h8000, 16'h8000, 16'hFFFF};
      tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFFE};
      tbl[3] = '{16'h8000, 16'h0000, 16'h8000, 16'h8000};
      tbl[4] = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'h8000};
      tbl[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0002};
      tbl[6] = '{16'h0100, 16'h0000, 16'h0100, 16'h0100};
      tbl[7] = '{16'h0000, 16'hFFFB, 16'h0000, 16'h0005};

      rst_n = 1'b0; din_re = '0; din_im = '0; din_valid = 1'b0; din_last = 1'b0;
      rx_ready = 1'b0;
      repeat (3) tick();
      for (int g = 0; g < 2; g++) begin
         check($sformatf("rst_tx_m%0d", g), int'(txs[g]), 1);
         check($sformatf("rst_tx_ready_m%0d", g), int'(txr[g]), 1);
         check($sformatf("rst_busy_m%0d", g), int'(bsy[g]), 0);
         check($sformatf("rst_drop_m%0d", g), int'(fd[g]), 0);
         check($sformatf("rst_err_m%0d", g), int'(fe[g]), 0);
      end
      rst_n = 1'b1;
      tick();

      // Basic frame with exact latency and duration
      rx_ready = 1'b1;
      fec = fe_cnt[0];
      junk_align();
      for (int i = 0; i < DEP; i++) begin
         fre[i] = 16'h0100 + i;
         fim[i] = int'($urandom_range(0, 65535));
      end
      b0 = rxn[0]; b1 = rxn[1];
      send_frame(DEP);
      e = cyc;
      check("basic_tx_ready_low", int'(txr[0]), 0);
      check("basic_busy_high", int'(bsy[0]), 1);
      tick();
      check("basic_tx_idle_e1", int'(txs[0]), 1);
      tick();
      check("basic_start_e2", int'(txs[0]), 0);
      s0 = e + 2;
      while (txr[0] !== 1'b1 && cyc < s0 + 2000) tick();
      check("basic_duration", cyc - s0, 2 * DEP * 10 * CD);
      check("basic_busy_low", int'(bsy[0]), 0);
      tick();
      check("basic_first_start", stc[0][b0], s0);
      check_frame("basic", b0, b1);
      check("basic_no_err", fe_cnt[0] - fec, 0);

      // Table-driven word processing for both modes
      junk_align();
      for (int i = 0; i < 8; i++) begin
         fre[i] = int'(tbl[i].re);
         fim[i] = int'(tbl[i].im);
      end
      b0 = rxn[0]; b1 = rxn[1];
      send_frame(DEP);
      wait_idle("table");
      for (int i = 0; i < 8; i++) begin
         check($sformatf("table_re_%0d", i), dec_word(0, b0, i), int'(tbl[i].w0));
         check($sformatf("table_mag_%0d", i), dec_word(1, b1, i), int'(tbl[i].w1));
      end

      // Host pause in the middle of byte 3
      junk_align();
      rand_frame();
      b0 = rxn[0]; b1 = rxn[1];
      send_frame(DEP);
      s0 = cyc + 2;
      tick_until(s0 + 3 * 10 * CD + 10);
      rx_ready = 1'b0;
      tick_until(s0 + 4 * 10 * CD);
      check("pause_byte3_done", rxn[0] - b0, 4);
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (txs[0] !== 1'b1 || txs[1] !== 1'b1) bad++;
         tick();
      end
      check("pause_tx_held", bad, 0);
      rx_ready = 1'b1;
      d = 0;
      do begin
         tick();
         d++;
      end while (txs[0] !== 1'b0 && d < 4);
      check_rng("pause_resume_delay", d, 1, 2);
      wait_idle("pause");
      check_frame("pause", b0, b1);

      // A whole frame arriving during SEND is dropped
      junk_align();
      rand_frame();
      b0 = rxn[0]; b1 = rxn[1];
      send_frame(DEP);
      repeat (20) tick();
      fdc = fd_cnt[0];
      bad = 0;
      for (int i = 0; i < DEP; i++) begin
         send_beat(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                   i == DEP - 1, 1'b0);
         if (i < DEP - 1 && fd[0] !== 1'b0) bad++;
      end
      check("drop_pulse_m0", int'(fd[0]), 1);
      check("drop_pulse_m1", int'(fd[1]), 1);
      check("drop_no_early", bad, 0);
      tick();
      check("drop_one_cycle", int'(fd[0]), 0);
      wait_idle("drop");
      check("drop_count", fd_cnt[0] - fdc, 1);
      check_frame("drop", b0, b1);

      // Short frame: error, then next frame captured
      junk_align();
      fec = fe_cnt[0];
      for (int i = 0; i < 6; i++)
         send_beat(int'($urandom_range(0, 65535)), 0, i == 5, 1'b0);
      check("short_err_pulse", int'(fe[0]), 1);
      check("short_tx_ready", int'(txr[0]), 1);
      rand_frame();
      b0 = rxn[0]; b1 = rxn[1];
      send_frame(DEP);
      wait_idle("short");
      check("short_err_count", fe_cnt[0] - fec, 1);
      check_frame("short_next", b0, b1);

      // Long frame: error on the 8th beat, 9th beat's last resyncs
      junk_align();
      fec = fe_cnt[0];
      rand_frame();
      for (int i = 0; i < 9; i++) begin
         send_beat(fre[i], fim[i], i == 8, 1'b0);
         if (i == 7) check("long_err_pulse", int'(fe[0]), 1);
      end
      check("long_tx_ready", int'(txr[0]), 1);
      rand_frame();
      b0 = rxn[0]; b1 = rxn[1];
      send_frame(DEP);
      wait_idle("long");
      check("long_err_count", fe_cnt[0] - fec, 1);
      check_frame("long_next", b0, b1);

      // Reset during a data bit of an all-zero first byte
      junk_align();
      rand_frame();
      fre[0] = 0;
      send_frame(DEP);
      s0 = cyc + 2;
      tick_until(s0 + 10);
      check("rst_mid_tx_before", int'(txs[0]), 0);
      #1 rst_n = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) begin
         check($sformatf("rst_mid_tx_m%0d", g), int'(txs[g]), 1);
         check($sformatf("rst_mid_tx_ready_m%0d", g), int'(txr[g]), 1);
         check($sformatf("rst_mid_busy_m%0d", g), int'(bsy[g]), 0);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      rand_frame();
      send_frame(DEP);
      check("rst_resync_discard", int'(txr[0]), 1);
      repeat (5) tick();
      check("rst_resync_idle", int'(bsy[0]), 0);
      rand_frame();
      b0 = rxn[0]; b1 = rxn[1];
      send_frame(DEP);
      check("rst_capture_ready", int'(txr[0]), 0);
      wait_idle("rst");
      check_frame("rst_next", b0, b1);

      check("stop_bits_m0", stopbad[0], 0);
      check("stop_bits_m1", stopbad[1], 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
